// File: rtl/scs8hd_o211a_filt_1_if.sv
// Signal bundle between an o211a qualification term and its persistence filter.
// The master drives the raw level and controls; the slave is the filter.
interface scs8hd_o211a_filt_1_if;
    logic D;
    logic EN;
    logic CLR;
    logic Q;
    logic QRISE;
    logic QFALL;
    logic BUSY;
    logic GLITCH;

    modport master (
        output D, EN, CLR,
        input  Q, QRISE, QFALL, BUSY, GLITCH
    );

    modport slave (
        input  D, EN, CLR,
        output Q, QRISE, QFALL, BUSY, GLITCH
    );
endinterface

// File: rtl/scs8hd_o211a_filt_1.sv
// Synchronising persistence filter for the X output of an scs8hd_o211a_1 gate.
// D is resynchronised into CLK, and Q only follows a new level after it has
// held for FILT_CYCLES consecutive enabled cycles. Edge pulses and a sticky
// glitch flag report accepted and abandoned transitions.
module scs8hd_o211a_filt_1 #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned CW          = 4
) (
    input logic                   CLK,
    input logic                   RESETB,
    scs8hd_o211a_filt_1_if.slave  pins
`ifdef SC_USE_PG_PIN
    ,
    input logic                   vpwr,
    input logic                   vgnd,
    input logic                   vpb,
    input logic                   vnb
`endif
);

`ifndef SC_USE_PG_PIN
    supply1 vpwr;
    supply1 vpb;
    supply0 vgnd;
    supply0 vnb;
`endif

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } state_t;

    // Rails are tied in normal builds, so this only qualifies the enable
    // and leaves functional behaviour unchanged.
    logic pwr_ok;
    logic en_eff;
    assign pwr_ok = vpwr & vpb & ~vgnd & ~vnb;
    assign en_eff = pins.EN & pwr_ok;

    logic [SYNC_STAGES-1:0] s;
    logic                   ds;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n, cnt_inc;
    logic           q, q_n;
    logic           qrise, qrise_n;
    logic           qfall, qfall_n;
    logic           glitch, glitch_n;

    assign ds      = s[SYNC_STAGES-1];
    assign cnt_inc = cnt + CW'(1);

    // Synchroniser shift register; keeps running regardless of EN.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            s <= '0;
        end else begin
            s <= {s[SYNC_STAGES-2:0], pins.D};
        end
    end

    // Filter state, counter, output level, pulses and glitch flag.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state  <= STABLE;
            cnt    <= '0;
            q      <= 1'b0;
            qrise  <= 1'b0;
            qfall  <= 1'b0;
            glitch <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            q      <= q_n;
            qrise  <= qrise_n;
            qfall  <= qfall_n;
            glitch <= glitch_n;
        end
    end

    // Next-state decode: count mismatches, accept at FILT_CYCLES, flag abandons.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        q_n      = q;
        qrise_n  = 1'b0;
        qfall_n  = 1'b0;
        // A set event below overrides the clear on the same edge.
        glitch_n = glitch & ~pins.CLR;

        if (en_eff) begin
            if (ds != q) begin
                if (cnt_inc == CW'(FILT_CYCLES)) begin
                    q_n     = ds;
                    qrise_n = ds;
                    qfall_n = ~ds;
                    cnt_n   = '0;
                    state_n = STABLE;
                end else begin
                    cnt_n   = cnt_inc;
                    state_n = PEND;
                end
            end else if (state == PEND) begin
                glitch_n = 1'b1;
                cnt_n    = '0;
                state_n  = STABLE;
            end
        end
    end

    assign pins.Q      = q;
    assign pins.QRISE  = qrise;
    assign pins.QFALL  = qfall;
    assign pins.BUSY   = (state == PEND);
    assign pins.GLITCH = glitch;

endmodule

// File: doc/scs8hd_o211a_filt_1.md
# scs8hd_o211a_filt_1

Synchronising persistence filter placed directly downstream of an `scs8hd_o211a_1` gate. It consumes the gate's X output on input D, resynchronises it into the CLK domain, and only changes registered output Q after the new level has held for FILT_CYCLES consecutive enabled cycles. It also reports one-cycle edge pulses and a sticky glitch flag for rejected transitions. Used where a gated o211a qualification term feeds sequential logic and must be clean and debounced.

## Interface
- SYNC_STAGES, 2, synchroniser depth on D; legal range 2..3.
- FILT_CYCLES, 4, consecutive enabled cycles a changed level must persist before Q follows; legal range 1..15.
- CW, 4, counter width (fixed 4, covers FILT_CYCLES max).
- CLK  input  1  sole clock, all state updates on rising edge.
- RESETB  input  1  reset; synchronous, active-low.
- D  input  1  X of upstream scs8hd_o211a_1, (A1|A2)&B1&C1; asynchronous to CLK.
- EN  input  1  filter enable; low freezes filter state (synchroniser keeps running).
- CLR  input  1  synchronous clear of GLITCH.
- Q  output  1  filtered, registered level.
- QRISE  output  1  registered one-cycle pulse, same edge Q goes 0->1.
- QFALL  output  1  registered one-cycle pulse, same edge Q goes 1->0.
- BUSY  output  1  high while a candidate change is pending (state PEND).
- GLITCH  output  1  sticky; set when a pending change is abandoned.
- vpwr, vgnd, vpb, vnb  input  1 each  present only under SC_USE_PG_PIN; otherwise supply1/supply0 nets internally.

## Operation
- Synchroniser: shift register s[SYNC_STAGES-1:0], s[0] <= D; ds = s[SYNC_STAGES-1].
- States: STABLE (cnt=0) and PEND (cnt = consecutive mismatch cycles seen, 1..FILT_CYCLES-1).
- Each edge with RESETB=1 and EN=1:
  - ds != Q: cnt_next = cnt+1. If cnt_next == FILT_CYCLES, then Q <= ds, QRISE/QFALL per direction, cnt <= 0, state STABLE. Otherwise cnt <= cnt_next, state PEND.
  - ds == Q in PEND: GLITCH <= 1, cnt <= 0, state STABLE, Q unchanged.
  - ds == Q in STABLE: no change.
- EN=0: state, cnt, Q, GLITCH-set logic frozen; QRISE/QFALL 0; CLR still honoured.
- FILT_CYCLES=1: STABLE never enters PEND; Q follows ds on first enabled mismatch edge; BUSY never asserts.
- GLITCH: CLR=1 clears it. A set event on the same edge as CLR=1 wins, so GLITCH=1.
- BUSY = (state == PEND), decoded from registered state.
- Counter compare on CW bits; cnt never exceeds FILT_CYCLES-1.

## Timing
- Reset (RESETB=0 at an edge): s all 0, Q=0, QRISE=0, QFALL=0, BUSY=0, GLITCH=0, cnt=0, state STABLE. This applies mid-PEND too: the pending change is discarded and no pulse is issued.
- First edge after RESETB returns high behaves as normal operation.
- D->Q latency with EN held high: SYNC_STAGES + FILT_CYCLES rising edges after D settles before an edge; default 6.
- QRISE/QFALL are high exactly one cycle, coincident with the Q update; never both high.
- Minimum D pulse that propagates to Q: FILT_CYCLES enabled cycles at ds. Shorter pulses set GLITCH if they reached PEND.
- No combinational path from any input to any output.

## Test plan
- Reset: hold RESETB=0 for 3 edges with D=1, EN=1 -> Q=0, BUSY=0, GLITCH=0, pulses 0. Release -> Q=1 exactly 6 edges later, QRISE high that cycle only.
- Clean rise/fall (defaults): D 0->1, held 20 cycles, then 1->0 -> QRISE at edge 6 after the rise, QFALL at edge 6 after the fall; BUSY high 3 cycles before each (cnt 1..3).
- Glitch: D high for 2 cycles, then low -> Q stays 0, BUSY pulses, GLITCH=1. CLR for one cycle -> GLITCH=0. Simultaneous glitch and CLR -> GLITCH=1.
- Enable freeze: D rises, EN dropped when cnt=2 for 5 cycles then raised -> BUSY held 1, cnt held 2, Q flips 2 enabled edges after EN returns.
- Reset mid-PEND: D rises, RESETB=0 for one edge at cnt=3 -> no QRISE, Q=0, BUSY=0. With D still 1, Q=1 at edge 6 after release.
- FILT_CYCLES=1, SYNC_STAGES=3: D toggles every 4 cycles -> Q follows with 4-edge latency, BUSY never 1, GLITCH never 1.
